// File: rtl/priority_code_decoder.sv
// priority_code_decoder
//
// Receiving end of the priority-encoder path. Accepts 3-bit priority codes
// over a valid/ready handshake and decodes each legal code into a 2-bit class
// index and a 4-bit one-hot line. Each decode is held for HOLD_CYCLES cycles
// so slow downstream logic can sample it. Illegal multi-hot codes raise a
// one-cycle err pulse. Saturating occurrence counters are kept per class and
// for errors.
//
// Parameters
//   HOLD_CYCLES  cycles dec_valid stays high per accepted legal code (>= 1)
//   CNT_W        width of each occurrence counter
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous active-high reset
//   code_valid  in   1      upstream code present
//   code        in   3      priority code (000, 001, 010, 100 legal)
//   code_ready  out  1      block can accept a code this cycle
//   cnt_clr     in   1      synchronous clear of all counters (wins over increment)
//   cnt_sel     in   2      class counter driven on cnt_out
//   dec_valid   out  1      decoded output valid
//   dec_idx     out  2      decoded class index (0 when not valid)
//   dec_onehot  out  4      1 << dec_idx when valid, else 0
//   err         out  1      one-cycle pulse after an accepted illegal code
//   cnt_out     out  CNT_W  selected class counter
//   err_cnt     out  CNT_W  illegal-code counter

module priority_code_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [2:0]       code,
  output logic             code_ready,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic             dec_valid,
  output logic [1:0]       dec_idx,
  output logic [3:0]       dec_onehot,
  output logic             err,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0] err_cnt
);

  // Hold counter needs at least one bit even when HOLD_CYCLES is 1.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Code classification helpers.
  function automatic logic is_legal(input logic [2:0] c);
    case (c)
      3'b000, 3'b001, 3'b010, 3'b100: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] code_to_idx(input logic [2:0] c);
    case (c)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Saturating increment: stays at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic              xfer_p0;
  logic              legal_p0;
  logic [1:0]        idx_p0;
  logic              legal_xfer_p0;
  logic              illegal_xfer_p0;

  logic [1:0]        idx_p1;
  logic              err_p1;
  logic [CNT_W-1:0]  cls_cnt [4];
  logic [CNT_W-1:0]  err_cnt_p1;

  // ---- stage p0: handshake and combinational decode of the incoming code ----
  assign code_ready      = (state == IDLE);
  assign xfer_p0         = code_valid && code_ready;
  assign legal_p0        = is_legal(code);
  assign idx_p0          = code_to_idx(code);
  assign legal_xfer_p0   = xfer_p0 && legal_p0;
  assign illegal_xfer_p0 = xfer_p0 && !legal_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (legal_xfer_p0) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // ---- stage p1: registered decode result, error pulse and counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= illegal_xfer_p0;
      if (legal_xfer_p0) begin
        idx_p1 <= idx_p0;
      end else if (state == HOLD && hold_cnt == '0) begin
        idx_p1 <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cls_cnt[i] <= '0;
      end
      err_cnt_p1 <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) begin
        cls_cnt[i] <= '0;
      end
      err_cnt_p1 <= '0;
    end else begin
      if (legal_xfer_p0) begin
        cls_cnt[idx_p0] <= sat_inc(cls_cnt[idx_p0]);
      end
      if (illegal_xfer_p0) begin
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

  // Outputs are gated by state so they read zero whenever no decode is held.
  assign dec_valid  = (state == HOLD);
  assign dec_idx    = dec_valid ? idx_p1 : 2'd0;
  assign dec_onehot = dec_valid ? (4'b0001 << idx_p1) : 4'b0000;
  assign err        = err_p1;
  assign cnt_out    = cls_cnt[cnt_sel];
  assign err_cnt    = err_cnt_p1;

endmodule

// File: doc/priority_code_decoder.md
# priority_code_decoder

Receiving end of the priority-encoder path: accepts 3-bit priority codes (`000`, `001`, `010`, `100`) over a valid/ready handshake and decodes each into a 2-bit class index and a 4-bit one-hot line. Each decoded line is held for a programmable number of cycles so slow downstream logic (LEDs, display mux) can sample it. The block flags illegal multi-hot codes and keeps saturating per-class and error occurrence counters. It sits directly downstream of the priority encoder in the chapter-3 demo datapath.

## Interface
- `HOLD_CYCLES`, default 4: cycles `dec_valid` stays high per accepted legal code; legal range ≥1.
- `CNT_W`, default 8: width of each occurrence counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `code_valid`  in  1  upstream code present.
- `code`  in  3  priority code `{en,in}`-style.
- `code_ready`  out  1  block can accept a code this cycle.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `cnt_sel`  in  2  selects the class counter driven on `cnt_out`.
- `dec_valid`  out  1  decoded output valid, held `HOLD_CYCLES` cycles.
- `dec_idx`  out  2  decoded class index.
- `dec_onehot`  out  4  `1 << dec_idx` while valid, else `0000`.
- `err`  out  1  one-cycle pulse on an accepted illegal code.
- `cnt_out`  out  CNT_W  selected class counter (combinational mux of registers).
- `err_cnt`  out  CNT_W  illegal-code counter.

## Operation
- Decode map: `000`→idx 0; `001`→idx 1; `010`→idx 2; `100`→idx 3. `011`, `101`, `110`, `111` are illegal.
- Transfer occurs when `code_valid && code_ready` at a rising edge.
- FSM, two states:
  - IDLE: `code_ready`=1.
    - On a legal transfer: register idx and one-hot, load hold counter with `HOLD_CYCLES-1`, increment the class counter, go to HOLD.
    - On an illegal transfer: `err`=1 next cycle, increment `err_cnt`, stay in IDLE; decode outputs unchanged (0).
  - HOLD: `code_ready`=0, `dec_valid`=1, `dec_idx`/`dec_onehot` stable.
    - Hold counter decrements each cycle; at 0, go to IDLE. `dec_valid`, `dec_onehot` and `dec_idx` all return to 0 in IDLE.
- Counters saturate at all-ones; no wrap.
- `cnt_clr` zeroes all four class counters and `err_cnt`. When `cnt_clr` coincides with an increment, clear wins and the result is 0.
- `code_valid` or `code` changes while `code_ready`=0 are ignored; no buffering.
- Reset values (asynchronous, including mid-HOLD):
  - state IDLE
  - `code_ready`=1, with no transfer while `reset` is high
  - `dec_valid`=0, `dec_idx`=0, `dec_onehot`=0000
  - `err`=0, all counters 0

## Timing
- Legal code accepted at edge T: `dec_valid` high for cycles T+1 … T+HOLD_CYCLES; `code_ready` low over the same cycles; `code_ready` high again at T+HOLD_CYCLES+1.
- Counter increment is visible on `cnt_out`/`err_cnt` at T+1.
- Maximum legal throughput is one code per `HOLD_CYCLES+1` cycles. `dec_valid` is low for at least one cycle between consecutive decodes.
- Illegal code accepted at T: `err` high only during T+1. `code_ready` stays 1, so a new code can be accepted at T+1.
- `HOLD_CYCLES`=1: HOLD lasts exactly one cycle.

## Test plan
- Reset, then `code`=`100` with `code_valid` for one cycle at T → `dec_valid`=1 and `dec_onehot`=`1000` for T+1..T+4, `dec_idx`=3, `code_ready`=0 for T+1..T+4; with `cnt_sel`=3, `cnt_out`=1.
- `code_valid` held high with `code`=`001` → transfers at T, T+5, T+10; `dec_onehot`=`0010`; `dec_valid` low exactly one cycle between holds; class-1 counter = 3 after third transfer.
- Legal sequence `000`, `001`, `010`, `100` → `dec_onehot` `0001`, `0010`, `0100`, `1000` and `dec_idx` 0..3 in order.
- `code`=`011` then `code`=`110` on consecutive cycles → `err` pulses at T+1 and T+2, `err_cnt`=2, `dec_valid` stays 0, `code_ready` stays 1.
- Counter limits:
  - 300 transfers of `000` → class-0 counter reads 255 (`CNT_W`=8).
  - Then `cnt_clr` → all counters 0.
  - `cnt_clr` in the same cycle as a legal transfer → that class counter is 0.
- Reset asserted two cycles into a HOLD → `dec_valid`, `dec_onehot`, counters 0 immediately, without waiting for a clock edge; after release `code_ready`=1 and the next transfer decodes normally.
